// File: rtl/struct_pkg.sv
// Shared word layout for the struct packer/unpacker pair.
// Field order puts fourth at the MSB and first at the LSB of the packed word.
package struct_pkg;

    localparam int STRUCT_W = 4;

    typedef struct packed {
        logic fourth;
        logic third;
        logic second;
        logic first;
    } my_struct_t;

endpackage

// File: rtl/struct_fifo.sv
// Word buffer with natural-wrap pointers and occupancy count.
// Storage is reset so the head word reads as zero, never X, after reset.
module struct_fifo #(
    parameter int DEPTH    = 4,
    parameter int STRUCT_W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [STRUCT_W-1:0]          wr_data,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    output logic [STRUCT_W-1:0]          rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         push
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [STRUCT_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       count;
    logic                armed;
    logic                pop;

    // armed keeps wr_ready low until the first edge after reset release
    assign wr_ready = armed && (count != LW'(DEPTH));
    assign rd_valid = (count != '0);
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign rd_data  = mem[rd_ptr];
    assign level    = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            armed <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/struct_unpack_rx.sv
// Receive side: buffers packed words and presents the oldest as my_struct_t.
// Also keeps a saturating count of accepted words.
module struct_unpack_rx
    import struct_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [STRUCT_W-1:0]          in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output my_struct_t                   out_s,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [7:0]                   word_cnt
);

    logic [STRUCT_W-1:0] head;
    logic                push;

    struct_fifo #(
        .DEPTH    (DEPTH),
        .STRUCT_W (STRUCT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (in_data),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .rd_data  (head),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .level    (level),
        .push     (push)
    );

    assign out_s = my_struct_t'(head);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (push && (word_cnt != 8'hFF)) begin
            word_cnt <= word_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_struct_unpack_rx.sv
// Scenario bench for struct_unpack_rx: scoreboard queue filled on accepted
// pushes, drained and compared on every pop.
module tb_struct_unpack_rx;
    import struct_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    my_struct_t out_s;
    logic       out_valid;
    logic [2:0] level;
    logic [7:0] word_cnt;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] exp_q [$];
    logic       acc = 1'b0;
    int         rx_cnt = 0;
    int         sent;

    struct_unpack_rx #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_s     (out_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Mid-cycle monitor: inputs change 1 time unit after posedge, so the
    // negedge sees the settled handshake for the upcoming edge.
    always @(negedge clk) begin
        logic [3:0] e;
        logic [3:0] obs;
        if (rst_n) begin
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(in_data);
            if (out_valid && out_ready) begin
                obs = out_s;
                rx_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_underflow got %h want none", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        n_err++;
                        $display("FAIL sb_order got %h want %h", obs, e);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain;
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        while (level != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (level !== 3'd0) begin
            n_err++;
            $display("FAIL drain_timeout level got %0d want 0", level);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (level !== 3'd0)      begin n_err++; $display("FAIL rst_level got %0d want 0", level); end
        n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_s !== 4'b0000)   begin n_err++; $display("FAIL rst_out_s got %b want 0000", out_s); end
        n_cmp++; if (word_cnt !== 8'd0)   begin n_err++; $display("FAIL rst_word_cnt got %0d want 0", word_cnt); end
        rst_n = 1'b1;
        n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL rel_in_ready_early got %b want 0", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single;
        in_valid = 1'b1;
        in_data  = 4'b0001;
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL single_passthru got %b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1)  begin n_err++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_cmp++; if (out_s.first !== 1'b1) begin n_err++; $display("FAIL single_first got %b want 1", out_s.first); end
        n_cmp++; if ({out_s.fourth, out_s.third, out_s.second} !== 3'b000)
            begin n_err++; $display("FAIL single_upper got %b want 000", {out_s.fourth, out_s.third, out_s.second}); end
        n_cmp++; if (level !== 3'd1)      begin n_err++; $display("FAIL single_level got %0d want 1", level); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL single_empty got %b want 0", out_valid); end
    endtask

    task automatic test_full;
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            in_valid = 1'b1;
            in_data  = 4'(v);
            tick();
        end
        in_data = 4'd5;
        n_cmp++; if (level !== 3'd4)      begin n_err++; $display("FAIL full_level got %0d want 4", level); end
        n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        n_cmp++; if (out_s !== 4'b0001)   begin n_err++; $display("FAIL full_head got %b want 0001", out_s); end
        tick();
        tick();
        n_cmp++; if (level !== 3'd4)      begin n_err++; $display("FAIL full_hold_level got %0d want 4", level); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (level !== 3'd3)      begin n_err++; $display("FAIL full_pop_level got %0d want 3", level); end
        n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL full_pop_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (level !== 3'd4)      begin n_err++; $display("FAIL full_refill got %0d want 4", level); end
        drain();
    endtask

    task automatic test_back_to_back;
        in_valid = 1'b1;
        in_data  = 4'd6;
        tick();
        in_data  = 4'd7;
        tick();
        in_data  = 4'd8;
        n_cmp++; if (level !== 3'd2)      begin n_err++; $display("FAIL b2b_pre_level got %0d want 2", level); end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (level !== 3'd2)      begin n_err++; $display("FAIL b2b_level got %0d want 2", level); end
        n_cmp++; if (out_s !== 4'd7)      begin n_err++; $display("FAIL b2b_head got %0d want 7", out_s); end
        drain();
    endtask

    task automatic test_stream;
        int cyc;
        apply_reset();
        rx_cnt = 0;
        sent   = 0;
        cyc    = 0;
        while (rx_cnt < 10 && cyc < 400) begin
            in_valid  = (sent < 10);
            in_data   = sent[3:0];
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (rx_cnt !== 10)       begin n_err++; $display("FAIL stream_rx got %0d want 10", rx_cnt); end
        n_cmp++; if (word_cnt !== 8'd10)  begin n_err++; $display("FAIL stream_word_cnt got %0d want 10", word_cnt); end
        n_cmp++; if (level !== 3'd0)      begin n_err++; $display("FAIL stream_level got %0d want 0", level); end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        for (int v = 0; v < 3; v++) begin
            in_valid = 1'b1;
            in_data  = 4'(4'hA + v);
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (level !== 3'd3)      begin n_err++; $display("FAIL mid_pre_level got %0d want 3", level); end
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_cmp++; if (level !== 3'd0)      begin n_err++; $display("FAIL mid_level got %0d want 0", level); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL mid_in_ready got %b want 0", in_ready); end
        n_cmp++; if (out_s !== 4'b0000)   begin n_err++; $display("FAIL mid_out_s got %b want 0000", out_s); end
        n_cmp++; if (word_cnt !== 8'd0)   begin n_err++; $display("FAIL mid_word_cnt got %0d want 0", word_cnt); end
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale cycle %0d got %b want 0", k, out_valid); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturate;
        int cyc;
        apply_reset();
        out_ready = 1'b1;
        sent = 0;
        cyc  = 0;
        while (sent < 300 && cyc < 1000) begin
            in_valid = 1'b1;
            in_data  = sent[3:0];
            tick();
            if (acc) sent++;
            if (sent == 255) begin
                n_cmp++; if (word_cnt !== 8'd255) begin n_err++; $display("FAIL sat_edge got %0d want 255", word_cnt); end
            end
            cyc++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        n_cmp++; if (sent !== 300)        begin n_err++; $display("FAIL sat_sent got %0d want 300", sent); end
        n_cmp++; if (word_cnt !== 8'd255) begin n_err++; $display("FAIL sat_word_cnt got %0d want 255", word_cnt); end
        n_cmp++; if (level !== 3'd0)      begin n_err++; $display("FAIL sat_level got %0d want 0", level); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        test_saturate();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover got %0d words want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
